// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: single-outstanding valid/grant/rvalid memory port, 4-state FSM.
// Build option: define LSU_MISALIGN_TRAP_EN to turn misaligned H/W accesses into error ops.
module rv32i_lsu #(
    parameter int unsigned DPW = 32,
    parameter int unsigned BEW = DPW / 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ex_valid,
    output logic           ex_ready,
    input  logic           ex_store,
    input  logic [2:0]     ex_funct3,
    input  logic [DPW-1:0] ex_addr,
    input  logic [DPW-1:0] ex_wdata,
    output logic           mem_req,
    input  logic           mem_gnt,
    output logic           mem_we,
    output logic [BEW-1:0] mem_be,
    output logic [DPW-1:0] mem_addr,
    output logic [DPW-1:0] mem_wdata,
    input  logic           mem_rvalid,
    input  logic [DPW-1:0] mem_rdata,
    output logic           wb_valid,
    output logic [DPW-1:0] wb_rdata,
    output logic           wb_err
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e         state_q, state_d;
    logic [DPW-1:0] addr_q;
    logic [2:0]     funct3_q;
    logic           store_q;
    logic           err_q;
    logic [BEW-1:0] be_q;
    logic [DPW-1:0] wdata_q;
    logic [DPW-1:0] rdata_q;

    logic           accept;
    logic           op_err;
    logic           misalign;
    logic [BEW-1:0] be_n;
    logic [DPW-1:0] wdata_n;
    logic [1:0]     lane;
    logic [DPW-1:0] shifted;
    logic [DPW-1:0] load_ext;

    assign accept = ex_valid && (state_q == StIdle);

    // Decode the incoming op at accept time; results are registered with it.
    always_comb begin
        op_err   = 1'b0;
        misalign = 1'b0;
        be_n     = 4'b1111;
        wdata_n  = ex_wdata;
        unique case (ex_funct3)
            3'b000, 3'b001, 3'b010: op_err = 1'b0;
            3'b100, 3'b101:         op_err = ex_store;
            default:                op_err = 1'b1;
        endcase
        case (ex_funct3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << ex_addr[1:0];
                wdata_n = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                be_n     = 4'b0011 << {ex_addr[1], 1'b0};
                wdata_n  = {2{ex_wdata[15:0]}};
                misalign = ex_addr[0];
            end
            default: begin
                be_n     = 4'b1111;
                wdata_n  = ex_wdata;
                misalign = (ex_addr[1:0] != 2'b00);
            end
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        op_err = op_err || misalign;
`endif
    end

    // Byte lane of the loaded item; H ignores addr[0], W always sits at lane 0.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   lane = addr_q[1:0];
            2'b01:   lane = {addr_q[1], 1'b0};
            default: lane = 2'b00;
        endcase
        shifted = mem_rdata >> {lane, 3'b000};
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{shifted[7] & ~funct3_q[2]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{shifted[15] & ~funct3_q[2]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= ex_addr;
                funct3_q <= ex_funct3;
                store_q  <= ex_store;
                err_q    <= op_err;
                be_q     <= be_n;
                wdata_q  <= wdata_n;
                rdata_q  <= '0;
            end
            if (state_q == StWait && mem_rvalid && !store_q) begin
                rdata_q <= load_ext;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (ex_valid) state_d = op_err ? StResp : StReq;
            StReq:  if (mem_gnt) state_d = StWait;
            StWait: if (mem_rvalid) state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ex_ready  = (state_q == StIdle);
        mem_req   = (state_q == StReq);
        mem_we    = mem_req & store_q;
        mem_be    = mem_req ? be_q : '0;
        mem_addr  = mem_req ? {addr_q[DPW-1:2], 2'b00} : '0;
        mem_wdata = mem_req ? wdata_q : '0;
        wb_valid  = (state_q == StResp);
        wb_err    = wb_valid & err_q;
        wb_rdata  = wb_valid ? rdata_q : '0;
    end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed self-checking bench for rv32i_lsu; memory side is driven cycle by cycle.
module tb_rv32i_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic        mem_req, mem_gnt, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_rdata;
    logic        wb_err;

    int n_tests = 0;
    int n_fail  = 0;

    rv32i_lsu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_store  (ex_store),
        .ex_funct3 (ex_funct3),
        .ex_addr   (ex_addr),
        .ex_wdata  (ex_wdata),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_rdata  (wb_rdata),
        .wb_err    (wb_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one op; expect_mem=0 means an error op that must skip memory entirely.
    task automatic do_op(input string name, input logic store, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input int gnt_delay,
                         input logic [31:0] rdata, input logic expect_mem,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                         input logic exp_err);
        check_eq({name, ".ready"}, {31'b0, ex_ready}, 32'd1);
        ex_valid  = 1'b1;
        ex_store  = store;
        ex_funct3 = f3;
        ex_addr   = addr;
        ex_wdata  = wdata;
        next_cycle();
        ex_valid = 1'b0;
        if (expect_mem) begin
            for (int i = 0; i < gnt_delay; i++) begin
                check_eq({name, ".stall_req"}, {31'b0, mem_req}, 32'd1);
                check_eq({name, ".stall_addr"}, mem_addr, exp_addr);
                check_eq({name, ".stall_be"}, {28'b0, mem_be}, {28'b0, exp_be});
                check_eq({name, ".stall_ready"}, {31'b0, ex_ready}, 32'd0);
                next_cycle();
            end
            mem_gnt = 1'b1;
            check_eq({name, ".req"}, {31'b0, mem_req}, 32'd1);
            check_eq({name, ".we"}, {31'b0, mem_we}, {31'b0, store});
            check_eq({name, ".be"}, {28'b0, mem_be}, {28'b0, exp_be});
            check_eq({name, ".addr"}, mem_addr, exp_addr);
            check_eq({name, ".wdata"}, mem_wdata, exp_wdata);
            next_cycle();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            check_eq({name, ".wait_req"}, {31'b0, mem_req}, 32'd0);
            check_eq({name, ".wait_wbv"}, {31'b0, wb_valid}, 32'd0);
            next_cycle();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end else begin
            check_eq({name, ".no_req"}, {31'b0, mem_req}, 32'd0);
        end
        check_eq({name, ".wb_valid"}, {31'b0, wb_valid}, 32'd1);
        check_eq({name, ".wb_err"}, {31'b0, wb_err}, {31'b0, exp_err});
        check_eq({name, ".wb_rdata"}, wb_rdata, exp_rdata);
        next_cycle();
        check_eq({name, ".wb_done"}, {31'b0, wb_valid}, 32'd0);
        check_eq({name, ".idle_ready"}, {31'b0, ex_ready}, 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        ex_valid   = 1'b0;
        ex_store   = 1'b0;
        ex_funct3  = 3'b000;
        ex_addr    = 32'h0;
        ex_wdata   = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        next_cycle();
        next_cycle();
        check_eq("rst.ready", {31'b0, ex_ready}, 32'd1);
        check_eq("rst.req", {31'b0, mem_req}, 32'd0);
        check_eq("rst.we", {31'b0, mem_we}, 32'd0);
        check_eq("rst.be", {28'b0, mem_be}, 32'd0);
        check_eq("rst.addr", mem_addr, 32'd0);
        check_eq("rst.wdata", mem_wdata, 32'd0);
        check_eq("rst.wbv", {31'b0, wb_valid}, 32'd0);
        check_eq("rst.wbd", wb_rdata, 32'd0);
        check_eq("rst.err", {31'b0, wb_err}, 32'd0);
        rst_n = 1'b1;
        next_cycle();

        do_op("sw", 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h12345678, 1,
              32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
        do_op("lb", 0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF1234, 1,
              32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 0);
        do_op("lbu", 0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF1234, 1,
              32'h100, 4'b1000, 32'h0, 32'h00000080, 0);
        do_op("lh", 0, 3'b001, 32'h102, 32'h0, 0, 32'h80010000, 1,
              32'h100, 4'b1100, 32'h0, 32'hFFFF8001, 0);
        do_op("lhu", 0, 3'b101, 32'h102, 32'h0, 0, 32'h80010000, 1,
              32'h100, 4'b1100, 32'h0, 32'h00008001, 0);
        do_op("sh", 1, 3'b001, 32'h102, 32'h0000ABCD, 0, 32'h0, 1,
              32'h100, 4'b1100, 32'hABCDABCD, 32'h0, 0);
        do_op("sb", 1, 3'b000, 32'h301, 32'h123456A5, 0, 32'h0, 1,
              32'h300, 4'b0010, 32'hA5A5A5A5, 32'h0, 0);
        do_op("lb1", 0, 3'b000, 32'h301, 32'h0, 0, 32'h00007F00, 1,
              32'h300, 4'b0010, 32'h0, 32'h0000007F, 0);
        do_op("lw_stall", 0, 3'b010, 32'h200, 32'h0, 5, 32'hCAFEF00D, 1,
              32'h200, 4'b1111, 32'h0, 32'hCAFEF00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        do_op("lw_mis", 0, 3'b010, 32'h101, 32'h0, 0, 32'h0, 0,
              32'h0, 4'b0000, 32'h0, 32'h0, 1);
        do_op("lh_mis", 0, 3'b001, 32'h101, 32'h0, 0, 32'h0, 0,
              32'h0, 4'b0000, 32'h0, 32'h0, 1);
`else
        do_op("lw_mis", 0, 3'b010, 32'h101, 32'h0, 0, 32'h11223344, 1,
              32'h100, 4'b1111, 32'h0, 32'h11223344, 0);
        do_op("lh_mis", 0, 3'b001, 32'h103, 32'h0, 0, 32'hBEEF0000, 1,
              32'h100, 4'b1100, 32'h0, 32'hFFFFBEEF, 0);
`endif
        do_op("f3_011", 0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 0,
              32'h0, 4'b0000, 32'h0, 32'h0, 1);
        do_op("sbu", 1, 3'b100, 32'h100, 32'hFF, 0, 32'h0, 0,
              32'h0, 4'b0000, 32'h0, 32'h0, 1);
        do_op("f3_111", 0, 3'b111, 32'h100, 32'h0, 0, 32'h0, 0,
              32'h0, 4'b0000, 32'h0, 32'h0, 1);

        // Abandon an op in WAIT by pulsing reset; a late rvalid must be ignored.
        ex_valid  = 1'b1;
        ex_store  = 1'b0;
        ex_funct3 = 3'b010;
        ex_addr   = 32'h400;
        next_cycle();
        ex_valid = 1'b0;
        mem_gnt  = 1'b1;
        check_eq("abort.req", {31'b0, mem_req}, 32'd1);
        next_cycle();
        mem_gnt = 1'b0;
        check_eq("abort.wait_ready", {31'b0, ex_ready}, 32'd0);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        check_eq("abort.ready", {31'b0, ex_ready}, 32'd1);
        check_eq("abort.req0", {31'b0, mem_req}, 32'd0);
        check_eq("abort.wbv0", {31'b0, wb_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55555555;
        next_cycle();
        mem_rvalid = 1'b0;
        check_eq("abort.wbv1", {31'b0, wb_valid}, 32'd0);
        next_cycle();
        check_eq("abort.wbv2", {31'b0, wb_valid}, 32'd0);
        check_eq("abort.idle", {31'b0, ex_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
